rectifier: RTL

RECTIFIER -- requirements
Module: rectifier

---
 rtl/rectifier_if.sv | 42 ++++
 rtl/rectifier.sv | 81 ++++++++
 2 files changed

// File: rtl/rectifier_if.sv
// rectifier_if: handshake channels of the rectifier activation node
//   argument_*: signed 16-bit weighted sum from the upstream node (valid/data in, ready out)
//   result_*:   unsigned 8-bit activation to the next layer (valid/data out, ready in)
//   error_*:    signed 16-bit error fed back from downstream (valid/data in, ready out)
//   delta_*:    signed 16-bit local gradient to the upstream node (valid/data out, ready in)
//   slave modport is the rectifier's view, master modport is the environment's view.
interface rectifier_if;
    logic        argument_valid;
    logic [15:0] argument_data;
    logic        argument_ready;
    logic        result_valid;
    logic [7:0]  result_data;
    logic        result_ready;
    logic        error_valid;
    logic [15:0] error_data;
    logic        error_ready;
    logic        delta_valid;
    logic [15:0] delta_data;
    logic        delta_ready;

    modport slave (
        input  argument_valid, argument_data,
        output argument_ready,
        output result_valid, result_data,
        input  result_ready,
        input  error_valid, error_data,
        output error_ready,
        output delta_valid, delta_data,
        input  delta_ready
    );

    modport master (
        output argument_valid, argument_data,
        input  argument_ready,
        input  result_valid, result_data,
        output result_ready,
        output error_valid, error_data,
        input  error_ready,
        input  delta_valid, delta_data,
        output delta_ready
    );
endinterface

// File: rtl/rectifier.sv
// rectifier: clamped ReLU activation node with backpropagated gradient gating
//   clock: sole clock, rising edge
//   reset: asynchronous active-low reset
//   train: training enable, sampled when an argument is accepted
//   bus:   argument/result/error/delta handshake channels (rectifier_if.slave)
//   SHIFT: arithmetic right shift applied to the argument before clamping (0..8)
module rectifier #(
    parameter int SHIFT = 0
) (
    input logic        clock,
    input logic        reset,
    input logic        train,
    rectifier_if.slave bus
);
    if (SHIFT < 0 || SHIFT > 8) begin : g_bad_shift
        $error("rectifier: SHIFT must be in 0..8");
    end

    typedef enum logic [1:0] {RDY = 2'd0, RES = 2'd1, ERR = 2'd2, DEL = 2'd3} state_t;

    state_t             state;
    logic signed [15:0] arg;
    logic               train_q;
    logic signed [15:0] s_in;
    logic signed [15:0] s_arg;
    logic [7:0]         clamp_in;
    logic               linear;

    // s_in feeds the activation in the accept cycle; s_arg (from the held
    // argument) decides later whether the gradient passes through.
    always_comb begin
        s_in     = $signed(bus.argument_data) >>> SHIFT;
        s_arg    = arg >>> SHIFT;
        clamp_in = (s_in <= 16'sd0) ? 8'h00 : (s_in > 16'sd255) ? 8'hff : s_in[7:0];
        linear   = (s_arg > 16'sd0) && (s_arg <= 16'sd255);
    end

    assign bus.argument_ready = (state == RDY);
    assign bus.error_ready    = (state == ERR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= RDY;
            arg              <= '0;
            train_q          <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_data  <= 8'h00;
            bus.delta_valid  <= 1'b0;
            bus.delta_data   <= 16'h0000;
        end else begin
            case (state)
                RDY: if (bus.argument_valid) begin
                    arg              <= $signed(bus.argument_data);
                    train_q          <= train;
                    bus.result_data  <= clamp_in;
                    bus.result_valid <= 1'b1;
                    state            <= RES;
                end
                RES: if (bus.result_ready) begin
                    bus.result_valid <= 1'b0;
                    state            <= train_q ? ERR : RDY;
                end
                ERR: if (bus.error_valid) begin
                    // saturated, zero and negative regions carry no gradient
                    bus.delta_data  <= linear ? bus.error_data : 16'h0000;
                    bus.delta_valid <= 1'b1;
                    state           <= DEL;
                end
                DEL: if (bus.delta_ready) begin
                    bus.delta_valid <= 1'b0;
                    state           <= RDY;
                end
                default: begin
                    bus.result_valid <= 1'b0;
                    bus.delta_valid  <= 1'b0;
                    state            <= RDY;
                end
            endcase
        end
    end
endmodule
